// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if - every non-clock signal of mem_arbiter in one bundle.
//   Fetch port : if_valid/if_addr in, if_ready/if_rvalid/if_rdata out.
//   Data port  : d_valid/d_we/d_addr/d_wdata/d_wstrb in,
//                d_ready/d_rvalid/d_rdata out.
//   Memory port: mem_valid/mem_we/mem_addr/mem_wdata/mem_wstrb out,
//                mem_ready/mem_rvalid/mem_rdata in.
//   owner      : 0 = fetch, 1 = data; owner of current/last transaction.
// Modports: slave = arbiter view, master = environment (requesters + memory).
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              if_valid;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_valid;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [STRB_W-1:0] d_wstrb;
    logic              d_ready;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    logic              owner;

    modport slave (
        input  if_valid, if_addr,
        output if_ready, if_rvalid, if_rdata,
        input  d_valid, d_we, d_addr, d_wdata, d_wstrb,
        output d_ready, d_rvalid, d_rdata,
        output mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rvalid, mem_rdata,
        output owner
    );

    modport master (
        output if_valid, if_addr,
        input  if_ready, if_rvalid, if_rdata,
        output d_valid, d_we, d_addr, d_wdata, d_wstrb,
        input  d_ready, d_rvalid, d_rdata,
        input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rvalid, mem_rdata,
        input  owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter - shares one memory port between instruction fetch and the
// load/store unit. One transaction outstanding at a time; round-robin on ties.
// Ports:
//   clk      core clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      mem_arbiter_if.slave (fetch, data and memory ports, owner)
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    mem_arbiter_if.slave    bus
);
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } req_t;

    logic [1:0]        state;
    // Winner of the most recent accept. It is both the round-robin history
    // and the owner output, so one register serves both.
    logic              last_grant;
    logic              grant_d;
    logic              grant_if;
    req_t              win;
    req_t              req;
    logic              mem_valid_q;
    logic              if_rvalid_q;
    logic              d_rvalid_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              done;

    // Arbitration happens only in IDLE; on a tie the side not granted last wins.
    always_comb begin
        grant_d  = 1'b0;
        grant_if = 1'b0;
        if (state == IDLE) begin
            grant_d  = bus.d_valid && (!bus.if_valid || !last_grant);
            grant_if = bus.if_valid && !grant_d;
        end
    end

    // Fields of the winner; a fetch is always a plain read with no strobes.
    always_comb begin
        win = '0;
        if (grant_d) begin
            win.we    = bus.d_we;
            win.addr  = bus.d_addr;
            win.wdata = bus.d_wdata;
            win.wstrb = bus.d_wstrb;
        end else begin
            win.addr  = bus.if_addr;
        end
    end

    // Completion: either rvalid arrives with the accepting mem_ready, or later
    // in WAIT. rvalid anywhere else belongs to nobody and is dropped.
    assign done = ((state == REQ) && bus.mem_ready && bus.mem_rvalid) ||
                  ((state == WAIT) && bus.mem_rvalid);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            last_grant  <= 1'b0;
            req         <= '0;
            mem_valid_q <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            if_rvalid_q <= done && !last_grant;
            d_rvalid_q  <= done && last_grant;
            if (done) begin
                if (last_grant) d_rdata_q  <= bus.mem_rdata;
                else            if_rdata_q <= bus.mem_rdata;
            end

            case (state)
                IDLE: begin
                    if (grant_d || grant_if) begin
                        req         <= win;
                        last_grant  <= grant_d;
                        mem_valid_q <= 1'b1;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (bus.mem_ready) begin
                        mem_valid_q <= 1'b0;
                        state       <= bus.mem_rvalid ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.if_ready  = grant_if;
    assign bus.d_ready   = grant_d;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_we    = req.we;
    assign bus.mem_addr  = req.addr;
    assign bus.mem_wdata = req.wdata;
    assign bus.mem_wstrb = req.wstrb;
    assign bus.owner     = last_grant;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter - scoreboard bench for mem_arbiter: a memory model answers
// mem_valid, a monitor predicts grants, memory requests and responses from
// the arbitration rules and compares them as the DUT presents them.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // requester / memory drives
    logic          if_valid = 0, d_valid = 0, d_we = 0;
    logic [AW-1:0] if_addr = 0, d_addr = 0;
    logic [DW-1:0] d_wdata = 0, mem_rdata = 0;
    logic [SW-1:0] d_wstrb = 0;
    logic          mem_ready = 0, mem_rvalid = 0;
    // DUT outputs
    logic          if_ready, if_rvalid, d_ready, d_rvalid, mem_valid, mem_we, owner;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [SW-1:0] mem_wstrb;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    assign bus.if_valid   = if_valid;
    assign bus.if_addr    = if_addr;
    assign bus.d_valid    = d_valid;
    assign bus.d_we       = d_we;
    assign bus.d_addr     = d_addr;
    assign bus.d_wdata    = d_wdata;
    assign bus.d_wstrb    = d_wstrb;
    assign bus.mem_ready  = mem_ready;
    assign bus.mem_rvalid = mem_rvalid;
    assign bus.mem_rdata  = mem_rdata;
    assign if_ready  = bus.if_ready;
    assign if_rvalid = bus.if_rvalid;
    assign if_rdata  = bus.if_rdata;
    assign d_ready   = bus.d_ready;
    assign d_rvalid  = bus.d_rvalid;
    assign d_rdata   = bus.d_rdata;
    assign mem_valid = bus.mem_valid;
    assign mem_we    = bus.mem_we;
    assign mem_addr  = bus.mem_addr;
    assign mem_wdata = bus.mem_wdata;
    assign mem_wstrb = bus.mem_wstrb;
    assign owner     = bus.owner;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_chk = 0, n_pass = 0;
    function automatic void chk(input bit ok, input string name,
                                input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // ---------------- memory model ----------------
    bit          rnd_mode = 0, fix_data = 0, inject_stale = 0, stale_pend = 0, real_rv = 0;
    int          spur_mode = 0;          // 0 none, 1 every allowed cycle, 2 random
    int          cfg_rdy = 0, cfg_rv = 1;
    logic [31:0] cfg_data = 0;
    int          m_st = 0, cnt = 0, rv_left = 0;

    function automatic bit spur_now();
        return (spur_mode == 1) || (spur_mode == 2 && $urandom_range(0, 3) == 0);
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        mem_ready = 0; mem_rvalid = 0; real_rv = 0;
        if (!reset_n) begin
            m_st = 0;
            stale_pend = inject_stale;
        end else if (stale_pend) begin
            mem_rvalid = 1; mem_rdata = $urandom; stale_pend = 0;
        end else begin
            if (m_st == 0 && mem_valid) begin
                m_st    = 1;
                cnt     = rnd_mode ? int'($urandom_range(0, 3)) : cfg_rdy;
                rv_left = rnd_mode ? int'($urandom_range(0, 3)) : cfg_rv;
            end
            if (m_st == 1) begin
                if (cnt == 0) begin
                    mem_ready = 1;
                    if (rv_left == 0) begin
                        mem_rvalid = 1; real_rv = 1; m_st = 0;
                        mem_rdata = fix_data ? cfg_data : $urandom;
                    end else m_st = 2;
                end else begin
                    cnt--;
                    if (spur_now()) begin mem_rvalid = 1; mem_rdata = $urandom; end
                end
            end else if (m_st == 2) begin
                rv_left--;
                if (rv_left == 0) begin
                    mem_rvalid = 1; real_rv = 1; m_st = 0;
                    mem_rdata = fix_data ? cfg_data : $urandom;
                end
            end else if (spur_now()) begin
                mem_rvalid = 1; mem_rdata = $urandom;
            end
        end
    end

    // ---------------- reference model + scoreboard monitor ----------------
    typedef struct { bit owner; bit we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; int cyc; } txn_t;
    typedef struct { bit owner; logic [31:0] data; int cyc; } rsp_t;
    txn_t req_q[$];
    rsp_t rsp_q[$];
    bit   m_idle = 1, m_last = 0, cur_owner = 0;
    logic [31:0] exp_ird = 0, exp_drd = 0;

    initial begin : monitor
        txn_t t;
        rsp_t r;
        bit   exp_d, exp_i;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                req_q.delete(); rsp_q.delete();
                m_idle = 1; m_last = 0; cur_owner = 0; exp_ird = 0; exp_drd = 0;
            end else begin
                // responses: one pulse, the cycle after the completing mem_rvalid
                if (if_rvalid || d_rvalid) begin
                    if (rsp_q.size() == 0) chk(0, "rsp_unexpected", 64'({if_rvalid, d_rvalid}), 0);
                    else begin
                        r = rsp_q.pop_front();
                        chk(if_rvalid == !r.owner && d_rvalid == r.owner, "rsp_port",
                            64'({if_rvalid, d_rvalid}), r.owner ? 64'd1 : 64'd2);
                        chk(cyc == r.cyc + 1, "rsp_latency", 64'(cyc - r.cyc), 1);
                        if (r.owner) exp_drd = r.data; else exp_ird = r.data;
                        chk(if_rdata == exp_ird, "if_rdata", 64'(if_rdata), 64'(exp_ird));
                        chk(d_rdata == exp_drd, "d_rdata", 64'(d_rdata), 64'(exp_drd));
                    end
                    m_idle = 1;
                end else if (rsp_q.size() != 0 && cyc > rsp_q[0].cyc + 1) begin
                    chk(0, "rsp_missing", 0, 1);
                    rsp_q.delete(0);
                    m_idle = 1;
                end
                // grants: only when nothing is outstanding; tie goes to the side not granted last
                exp_d = m_idle && d_valid && (!if_valid || !m_last);
                exp_i = m_idle && if_valid && !exp_d;
                if (exp_d || exp_i || d_ready || if_ready) begin
                    chk(d_ready == exp_d && if_ready == exp_i, "grant",
                        64'({if_ready, d_ready}), 64'({exp_i, exp_d}));
                    if (exp_d || exp_i) begin
                        t.owner = exp_d;
                        t.we    = exp_d ? d_we : 1'b0;
                        t.addr  = exp_d ? d_addr : if_addr;
                        t.wdata = d_wdata;
                        t.wstrb = exp_d ? d_wstrb : 4'd0;
                        t.cyc   = cyc;
                        req_q.push_back(t);
                        m_idle = 0;
                        m_last = exp_d;
                    end
                end
                // memory request: present the cycle after accept, stable until mem_ready
                if (mem_valid) begin
                    if (req_q.size() == 0) chk(0, "mem_valid_unexpected", 1, 0);
                    else begin
                        t = req_q[0];
                        chk(mem_addr == t.addr && mem_we == t.we && mem_wstrb == t.wstrb &&
                            (!t.we || mem_wdata == t.wdata), "mem_fields",
                            64'({mem_we, mem_wstrb, mem_addr}), 64'({t.we, t.wstrb, t.addr}));
                        if (mem_ready) begin
                            chk(owner == t.owner, "owner", 64'(owner), 64'(t.owner));
                            cur_owner = t.owner;
                            req_q.delete(0);
                        end
                    end
                end else if (req_q.size() != 0 && cyc > req_q[0].cyc) begin
                    chk(0, "mem_valid_missing", 0, 1);
                    req_q.delete(0);
                end
                if (real_rv) rsp_q.push_back('{cur_owner, mem_rdata, cyc});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic settle();
        repeat (12) @(negedge clk);
    endtask

    task automatic do_req(input bit is_d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          input bit wait_rsp, output int t_acc, output int t_rsp);
        @(posedge clk); #1;
        if (is_d) begin d_valid = 1; d_we = we; d_addr = addr; d_wdata = wdata; d_wstrb = wstrb; end
        else begin if_valid = 1; if_addr = addr; end
        t_acc = -1; t_rsp = -1;
        for (int n = 0; n < 20 && t_acc < 0; n++) begin
            @(negedge clk);
            if (is_d ? d_ready : if_ready) t_acc = cyc;
        end
        @(posedge clk); #1;
        if_valid = 0; d_valid = 0;
        if (t_acc < 0) begin chk(0, "accept_timeout", 0, 1); return; end
        if (wait_rsp) begin
            for (int n = 0; n < 20 && t_rsp < 0; n++) begin
                @(negedge clk);
                if (is_d ? d_rvalid : if_rvalid) t_rsp = cyc;
            end
            if (t_rsp < 0) chk(0, "rsp_timeout", 0, 1);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk(!mem_valid && !mem_we && mem_addr == 0 && mem_wdata == 0 && mem_wstrb == 0,
            {tag, "_mem"}, 64'({mem_valid, mem_we, mem_wstrb, mem_addr}), 0);
        chk(!if_rvalid && !d_rvalid, {tag, "_rvalid"}, 64'({if_rvalid, d_rvalid}), 0);
        chk(if_rdata == 0 && d_rdata == 0, {tag, "_rdata"}, 64'({if_rdata, d_rdata}), 0);
        chk(owner == 0, {tag, "_owner"}, 64'(owner), 0);
    endtask

    initial begin : main
        int  ta, tr, t2, t3, g;
        bit  exp_seq, dr, hs;

        #1 reset_n = 0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        chk(!if_ready && !d_ready, "reset_ready", 64'({if_ready, d_ready}), 0);
        @(posedge clk); #2 reset_n = 1;
        settle();

        // fetch only, zero-wait memory
        cfg_rdy = 0; cfg_rv = 1; fix_data = 1; cfg_data = 32'h00500093;
        do_req(0, 0, 32'h40, 0, 0, 1, ta, tr);
        chk(tr - ta == 3, "fetch_latency", 64'(tr - ta), 3);
        chk(if_rdata == 32'h00500093, "fetch_data", 64'(if_rdata), 64'h00500093);
        settle();
        fix_data = 0;

        // ties after reset alternate data, fetch, data, fetch
        @(posedge clk); #2 reset_n = 0;
        @(posedge clk); #2 reset_n = 1;
        settle();
        @(posedge clk); #1;
        if_valid = 1; if_addr = 32'h80; d_valid = 1; d_we = 0; d_addr = 32'h200;
        exp_seq = 1; g = 0;
        for (int n = 0; n < 60 && g < 4; n++) begin
            @(negedge clk);
            if (if_ready || d_ready) begin
                chk(d_ready == exp_seq && if_ready == !exp_seq, "tie_grant",
                    64'({if_ready, d_ready}), 64'({!exp_seq, exp_seq}));
                exp_seq = !exp_seq; g++;
            end
        end
        if (g < 4) chk(0, "tie_timeout", 64'(g), 4);
        @(posedge clk); #1; if_valid = 0; d_valid = 0;
        settle();

        // store with mem_ready delayed 3 cycles
        cfg_rdy = 3; cfg_rv = 1;
        do_req(1, 1, 32'h100, 32'hDEADBEEF, 4'b0011, 1, ta, tr);
        chk(tr - ta == 6, "store_latency", 64'(tr - ta), 6);
        @(negedge clk);
        chk(!d_rvalid && !if_rvalid, "store_pulse", 64'({if_rvalid, d_rvalid}), 0);
        settle();

        // mem_ready and mem_rvalid together; a waiting fetch is taken at once
        cfg_rdy = 0; cfg_rv = 0;
        @(posedge clk); #1; d_valid = 1; d_we = 0; d_addr = 32'h300;
        ta = -1;
        for (int n = 0; n < 20 && ta < 0; n++) begin @(negedge clk); if (d_ready) ta = cyc; end
        @(posedge clk); #1; d_valid = 0; if_valid = 1; if_addr = 32'h44;
        t2 = -1; dr = 0;
        for (int n = 0; n < 20 && t2 < 0; n++) begin
            @(negedge clk);
            if (if_ready) begin t2 = cyc; dr = d_rvalid; end
        end
        chk(t2 == ta + 2, "coinc_accept", 64'(t2 - ta), 2);
        chk(dr, "coinc_rvalid", 64'(dr), 1);
        @(posedge clk); #1; if_valid = 0;
        t3 = -1;
        for (int n = 0; n < 20 && t3 < 0; n++) begin @(negedge clk); if (if_rvalid) t3 = cyc; end
        chk(t3 == t2 + 2, "coinc_fetch_latency", 64'(t3 - t2), 2);
        settle();

        // spurious mem_rvalid in IDLE and in REQ before mem_ready
        spur_mode = 1; cfg_rdy = 2; cfg_rv = 1;
        repeat (2) @(negedge clk);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk(!if_rvalid && !d_rvalid && !mem_valid, "spur_idle",
                64'({if_rvalid, d_rvalid, mem_valid}), 0);
        end
        do_req(0, 0, 32'h48, 0, 0, 1, ta, tr);
        chk(tr - ta == 5, "spur_latency", 64'(tr - ta), 5);
        settle();
        spur_mode = 0;

        // reset while in WAIT, then the stale completion arrives
        cfg_rdy = 0; cfg_rv = 6;
        do_req(1, 0, 32'h500, 0, 0, 0, ta, tr);
        hs = 0;
        for (int n = 0; n < 20 && !hs; n++) begin @(negedge clk); if (mem_valid && mem_ready) hs = 1; end
        chk(hs, "wait_reached", 64'(hs), 1);
        @(posedge clk); #2; inject_stale = 1; reset_n = 0;
        #1 chk_reset_vals("async_reset");
        repeat (2) @(posedge clk);
        #2; reset_n = 1; inject_stale = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk(!if_rvalid && !d_rvalid && !mem_valid, "stale_ignored",
                64'({if_rvalid, d_rvalid, mem_valid}), 0);
        end
        cfg_rv = 1;
        do_req(1, 0, 32'h504, 0, 0, 1, ta, tr);
        chk(tr - ta == 3, "post_reset_latency", 64'(tr - ta), 3);
        settle();

        // randomized traffic, memory delays and spurious completions
        rnd_mode = 1; spur_mode = 2;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            if_valid = ($urandom_range(0, 9) < 6);
            if_addr  = $urandom & 32'hFFFF_FFFC;
            d_valid  = ($urandom_range(0, 9) < 6);
            d_we     = 1'($urandom_range(0, 1));
            d_addr   = $urandom;
            d_wdata  = $urandom;
            d_wstrb  = 4'($urandom_range(0, 15));
        end
        @(posedge clk); #1; if_valid = 0; d_valid = 0;
        repeat (40) @(negedge clk);
        chk(req_q.size() == 0 && rsp_q.size() == 0 && m_idle, "drain",
            64'(req_q.size() + rsp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
